// File: rtl/cl_tpg_pkg.sv
// Shared types and constants for the Camera Link test pattern generator.
// Also holds the per-tap pixel function used by the top level.
package cl_tpg_pkg;

  localparam int TPG_TAPS  = 8;
  localparam int TPG_TAP_W = 8;
  localparam int TPG_CNT_W = 12;

  localparam logic [1:0] TPG_CONST = 2'd0;
  localparam logic [1:0] TPG_HRAMP = 2'd1;
  localparam logic [1:0] TPG_VRAMP = 2'd2;
  localparam logic [1:0] TPG_CHECK = 2'd3;

  typedef enum logic [1:0] {
    SRC_PASS = 2'd0,
    SRC_TEST = 2'd1,
    SRC_GAP  = 2'd2
  } src_state_t;

  typedef enum logic [2:0] {
    GEN_IDLE   = 3'd0,
    GEN_LEAD   = 3'd1,
    GEN_LINE   = 3'd2,
    GEN_HBLANK = 3'd3,
    GEN_VBLANK = 3'd4
  } gen_state_t;

  // (col*8+tap)[7:0] is simply {col[4:0], tap}
  function automatic logic [TPG_TAP_W-1:0] tpg_pixel(
    input logic [1:0]           mode,
    input logic [TPG_TAP_W-1:0] cval,
    input logic [TPG_CNT_W-1:0] col,
    input logic [TPG_CNT_W-1:0] row,
    input logic [2:0]           tap
  );
    case (mode)
      TPG_CONST: return cval;
      TPG_HRAMP: return {col[4:0], tap};
      TPG_VRAMP: return row[7:0];
      TPG_CHECK: return (col[3] ^ row[3]) ? 8'hFF : 8'h00;
      default:   return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/cl_tpg_timing.sv
// Test frame timing generator: LEAD / LINE / HBLANK / VBLANK sequencing with col/row counters.
// Line length and line count are captured whenever a frame starts.
module cl_tpg_timing
  import cl_tpg_pkg::*;
#(
  parameter int H_BLANK = 16,
  parameter int V_BLANK = 64,
  parameter int FV_LEAD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [TPG_CNT_W-1:0] line_len,
  input  logic [TPG_CNT_W-1:0] line_cnt,
  output gen_state_t           state,
  output logic                 frame_start,
  output logic                 fval,
  output logic                 lval,
  output logic [TPG_CNT_W-1:0] col,
  output logic [TPG_CNT_W-1:0] row
);

  localparam logic [TPG_CNT_W-1:0] LEAD_LAST = TPG_CNT_W'(FV_LEAD - 1);
  localparam logic [TPG_CNT_W-1:0] HB_LAST   = TPG_CNT_W'(H_BLANK - 1);
  localparam logic [TPG_CNT_W-1:0] VB_LAST   = TPG_CNT_W'(V_BLANK - 1);

  gen_state_t           state_r, state_nxt;
  logic [TPG_CNT_W-1:0] cnt_r, cnt_nxt;
  logic [TPG_CNT_W-1:0] col_r, col_nxt;
  logic [TPG_CNT_W-1:0] row_r, row_nxt;
  logic [TPG_CNT_W-1:0] len_r, len_nxt;
  logic [TPG_CNT_W-1:0] lines_r, lines_nxt;
  logic                 start_s;

  // Next-state and counter logic for the frame sequencer
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    col_nxt   = col_r;
    row_nxt   = row_r;
    len_nxt   = len_r;
    lines_nxt = lines_r;
    start_s   = 1'b0;
    case (state_r)
      GEN_IDLE: begin
        if (run) start_s = 1'b1;
        else     state_nxt = GEN_IDLE;
      end
      GEN_LEAD: begin
        if (cnt_r == LEAD_LAST) begin
          state_nxt = GEN_LINE;
          cnt_nxt   = 12'd0;
        end else begin
          cnt_nxt = cnt_r + 12'd1;
        end
      end
      GEN_LINE: begin
        if (col_r == len_r - 12'd1) begin
          col_nxt   = 12'd0;
          row_nxt   = row_r + 12'd1;
          state_nxt = (row_r == lines_r - 12'd1) ? GEN_VBLANK : GEN_HBLANK;
        end else begin
          col_nxt = col_r + 12'd1;
        end
      end
      GEN_HBLANK: begin
        if (cnt_r == HB_LAST) begin
          state_nxt = GEN_LINE;
          cnt_nxt   = 12'd0;
        end else begin
          cnt_nxt = cnt_r + 12'd1;
        end
      end
      GEN_VBLANK: begin
        if (cnt_r == VB_LAST) begin
          cnt_nxt = 12'd0;
          if (run) start_s   = 1'b1;
          else     state_nxt = GEN_IDLE;
        end else begin
          cnt_nxt = cnt_r + 12'd1;
        end
      end
      default: state_nxt = GEN_IDLE;
    endcase
    // A zero length or count behaves as one
    if (start_s) begin
      state_nxt = GEN_LEAD;
      cnt_nxt   = 12'd0;
      col_nxt   = 12'd0;
      row_nxt   = 12'd0;
      len_nxt   = (line_len == 12'd0) ? 12'd1 : line_len;
      lines_nxt = (line_cnt == 12'd0) ? 12'd1 : line_cnt;
    end else begin
      len_nxt   = len_r;
      lines_nxt = lines_r;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= GEN_IDLE;
      cnt_r   <= 12'd0;
      col_r   <= 12'd0;
      row_r   <= 12'd0;
      len_r   <= 12'd1;
      lines_r <= 12'd1;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      col_r   <= col_nxt;
      row_r   <= row_nxt;
      len_r   <= len_nxt;
      lines_r <= lines_nxt;
    end
  end

  assign state       = state_r;
  assign frame_start = start_s;
  assign fval        = (state_r == GEN_LEAD) || (state_r == GEN_LINE) || (state_r == GEN_HBLANK);
  assign lval        = (state_r == GEN_LINE);
  assign col         = col_r;
  assign row         = row_r;

endmodule

// File: rtl/cl_test_pattern_gen.sv
// Camera Link output source selector: registered pass-through or synthetic test frames.
// Source changes only at frame boundaries so no partial frame reaches the grabber.
module cl_test_pattern_gen
  import cl_tpg_pkg::*;
#(
  parameter int H_BLANK = 16,
  parameter int V_BLANK = 64,
  parameter int FV_LEAD = 4
) (
  input  logic        clk_txg,
  input  logic        rst_tx_n,
  input  logic        cmd_gen_test_image,
  input  logic [11:0] reg_test_image_chan_0,
  input  logic [11:0] reg_test_image_chan_1,
  input  logic [11:0] reg_test_image_chan_2,
  input  logic [11:0] reg_test_image_chan_3,
  input  logic [7:0]  in_chan_0,
  input  logic [7:0]  in_chan_1,
  input  logic [7:0]  in_chan_2,
  input  logic [7:0]  in_chan_3,
  input  logic [7:0]  in_chan_4,
  input  logic [7:0]  in_chan_5,
  input  logic [7:0]  in_chan_6,
  input  logic [7:0]  in_chan_7,
  input  logic        in_fval,
  input  logic        in_lval,
  output logic [7:0]  chan_0,
  output logic [7:0]  chan_1,
  output logic [7:0]  chan_2,
  output logic [7:0]  chan_3,
  output logic [7:0]  chan_4,
  output logic [7:0]  chan_5,
  output logic [7:0]  chan_6,
  output logic [7:0]  chan_7,
  output logic        fval,
  output logic        lval
);

  src_state_t           src_r, src_nxt;
  gen_state_t           gen_state_s;
  logic                 frame_start_s, gen_fval_s, gen_lval_s;
  logic [TPG_CNT_W-1:0] col_s, row_s;
  logic [1:0]           mode_r;
  logic [7:0]           const_r;
  logic [7:0]           in_tap_s [TPG_TAPS];
  logic [7:0]           data_nxt [TPG_TAPS];
  logic [7:0]           data_r   [TPG_TAPS];
  logic                 fval_nxt, lval_nxt, fval_r, lval_r;
  logic                 gen_idle_vb_s;
  logic                 unused_s;

  assign unused_s = ^{reg_test_image_chan_0[11:2], reg_test_image_chan_1[11:8]};

  assign in_tap_s[0] = in_chan_0;
  assign in_tap_s[1] = in_chan_1;
  assign in_tap_s[2] = in_chan_2;
  assign in_tap_s[3] = in_chan_3;
  assign in_tap_s[4] = in_chan_4;
  assign in_tap_s[5] = in_chan_5;
  assign in_tap_s[6] = in_chan_6;
  assign in_tap_s[7] = in_chan_7;

  cl_tpg_timing #(
    .H_BLANK(H_BLANK),
    .V_BLANK(V_BLANK),
    .FV_LEAD(FV_LEAD)
  ) u_timing (
    .clk        (clk_txg),
    .rst_n      (rst_tx_n),
    .run        (src_r == SRC_TEST),
    .line_len   (reg_test_image_chan_2),
    .line_cnt   (reg_test_image_chan_3),
    .state      (gen_state_s),
    .frame_start(frame_start_s),
    .fval       (gen_fval_s),
    .lval       (gen_lval_s),
    .col        (col_s),
    .row        (row_s)
  );

  assign gen_idle_vb_s = (gen_state_s == GEN_IDLE) || (gen_state_s == GEN_VBLANK);

  // Source selection: enter test between upstream frames, leave test at a test-frame boundary
  always_comb begin
    src_nxt = src_r;
    case (src_r)
      SRC_PASS: begin
        if (cmd_gen_test_image && !in_fval) src_nxt = SRC_TEST;
        else                                src_nxt = SRC_PASS;
      end
      SRC_TEST: begin
        if (!cmd_gen_test_image && gen_idle_vb_s) src_nxt = SRC_GAP;
        else                                      src_nxt = SRC_TEST;
      end
      SRC_GAP: begin
        if (!in_fval) src_nxt = SRC_PASS;
        else          src_nxt = SRC_GAP;
      end
      default: src_nxt = SRC_PASS;
    endcase
  end

  // Output mux feeding the output registers
  always_comb begin
    fval_nxt = 1'b0;
    lval_nxt = 1'b0;
    for (int k = 0; k < TPG_TAPS; k++) data_nxt[k] = 8'h00;
    case (src_r)
      SRC_PASS: begin
        fval_nxt = in_fval;
        lval_nxt = in_lval;
        for (int k = 0; k < TPG_TAPS; k++) data_nxt[k] = in_tap_s[k];
      end
      SRC_TEST: begin
        fval_nxt = gen_fval_s;
        lval_nxt = gen_lval_s;
        for (int k = 0; k < TPG_TAPS; k++)
          data_nxt[k] = gen_lval_s ? tpg_pixel(mode_r, const_r, col_s, row_s, 3'(k)) : 8'h00;
      end
      default: begin
        fval_nxt = 1'b0;
        lval_nxt = 1'b0;
      end
    endcase
  end

  // Source state, per-frame pattern settings and output registers
  always_ff @(posedge clk_txg or negedge rst_tx_n) begin
    if (!rst_tx_n) begin
      src_r   <= SRC_PASS;
      mode_r  <= TPG_CONST;
      const_r <= 8'h00;
      fval_r  <= 1'b0;
      lval_r  <= 1'b0;
      for (int k = 0; k < TPG_TAPS; k++) data_r[k] <= 8'h00;
    end else begin
      src_r  <= src_nxt;
      fval_r <= fval_nxt;
      lval_r <= lval_nxt;
      for (int k = 0; k < TPG_TAPS; k++) data_r[k] <= data_nxt[k];
      if (frame_start_s) begin
        mode_r  <= reg_test_image_chan_0[1:0];
        const_r <= reg_test_image_chan_1[7:0];
      end
    end
  end

  assign chan_0 = data_r[0];
  assign chan_1 = data_r[1];
  assign chan_2 = data_r[2];
  assign chan_3 = data_r[3];
  assign chan_4 = data_r[4];
  assign chan_5 = data_r[5];
  assign chan_6 = data_r[6];
  assign chan_7 = data_r[7];
  assign fval   = fval_r;
  assign lval   = lval_r;

endmodule
